serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 84 ++++++++
 tb/tb_serial_subtractor.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master side issues requests; the slave side (the subtractor) returns results.
interface serial_subtractor_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             B_in;
   logic [WIDTH-1:0] Diff;
   logic             B_out;
   logic             busy;
   logic             done;

   modport master (
      output start, A, B, B_in,
      input  Diff, B_out, busy, done
   );

   modport slave (
      input  start, A, B, B_in,
      output Diff, B_out, busy, done
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - B_in, LSB first, through one full-subtractor cell and a
// registered borrow; the result is published with a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | no operation, waiting for start
//   RUN   | one bit processed per cycle
//   DONE  | result published, done high for one cycle
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_subtractor_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] d_sr;
   logic             bor;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             bor_next;
   logic [WIDTH-1:0] d_shifted;

   always_comb begin
      d_bit     = a_sr[0] ^ b_sr[0] ^ bor;
      bor_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
      d_shifted = {d_bit, d_sr[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         d_sr      <= '0;
         bor       <= 1'b0;
         cnt       <= '0;
         bus.Diff  <= '0;
         bus.B_out <= 1'b0;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_sr     <= bus.A;
                  b_sr     <= bus.B;
                  bor      <= bus.B_in;
                  d_sr     <= '0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               bor  <= bor_next;
               d_sr <= d_shifted;
               cnt  <= cnt + 1'b1;
               // Terminal count: publish and leave RUN so the counter never wraps.
               if (cnt == LAST) begin
                  cnt       <= '0;
                  bus.Diff  <= d_shifted;
                  bus.B_out <= bor_next;
                  bus.busy  <= 1'b0;
                  bus.done  <= 1'b1;
                  state     <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor: the driver pushes expected results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_serial_subtractor;
   localparam int WIDTH = 4;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   int   done_count;
   int   overlap_count;
   logic [WIDTH:0] exp_q[$];

   serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (bus.busy && bus.done) overlap_count++;
      if (rst_n && bus.done) begin
         done_count++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            logic [WIDTH:0] e;
            e = exp_q.pop_front();
            chk("diff", int'(bus.Diff), int'(e[WIDTH:1]));
            chk("b_out", int'(bus.B_out), int'(e[0]));
         end
      end
   end

   // Drive a request at the current negedge and record its expected result.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input logic [WIDTH-1:0] ed, input logic eb);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      bus.B_in  = bin;
      exp_q.push_back({ed, eb});
   endtask

   // Advance until done; optionally inject an ignored start on cycle 2 of RUN.
   task automatic finish_op(input bit inj, output int n, output int busy_n);
      n = 0;
      busy_n = 0;
      do begin
         @(negedge clk);
         bus.start = 1'b0;
         n++;
         if (bus.busy) busy_n++;
         if (inj && n == 2) begin
            bus.start = 1'b1;
            bus.A     = 4'd1;
            bus.B     = 4'd5;
            bus.B_in  = 1'b0;
         end
      end while (!bus.done && n < 40);
      if (!bus.done) chk("done_timeout", 0, 1);
   endtask

   task automatic idle(input int cyc);
      repeat (cyc) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
   endtask

   initial begin
      int n, bn, dc;
      errors = 0; checks = 0; done_count = 0; overlap_count = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.B_in = 1'b0;
      #12;
      chk("rst_diff", int'(bus.Diff), 0);
      chk("rst_bout", int'(bus.B_out), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 11 - 7 - 1 = 3
      issue(4'b1011, 4'b0111, 1'b1, 4'b0011, 1'b0);
      finish_op(1'b0, n, bn);
      chk("basic_latency", n, WIDTH + 1);
      chk("basic_busy_cycles", bn, WIDTH);
      idle(3);
      chk("hold_diff", int'(bus.Diff), 3);
      chk("idle_busy", int'(bus.busy), 0);

      // 7 - 11 wraps to 12 with borrow
      issue(4'b0111, 4'b1011, 1'b0, 4'b1100, 1'b1);
      finish_op(1'b0, n, bn);
      idle(1);
      issue(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1);
      finish_op(1'b0, n, bn);
      idle(1);
      issue(4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0);
      finish_op(1'b0, n, bn);
      idle(2);

      // Busy protection: the injected 1 - 5 request must be dropped
      dc = done_count;
      issue(4'd9, 4'd2, 1'b0, 4'd7, 1'b0);
      finish_op(1'b1, n, bn);
      chk("protect_latency", n, WIDTH + 1);
      idle(10);
      chk("protect_done_count", done_count - dc, 1);

      // Back-to-back: 5 - 1 = 4, then 3 - 5 = 14 with borrow issued on the DONE cycle
      issue(4'd5, 4'd1, 1'b0, 4'd4, 1'b0);
      finish_op(1'b0, n, bn);
      issue(4'd3, 4'd5, 1'b0, 4'b1110, 1'b1);
      finish_op(1'b0, n, bn);
      chk("b2b_spacing", n, WIDTH + 1);
      chk("b2b_busy_cycles", bn, WIDTH);
      idle(1);

      // Asynchronous reset mid-RUN
      issue(4'd8, 4'd3, 1'b0, 4'd5, 1'b0);
      idle(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_diff", int'(bus.Diff), 0);
      chk("abort_bout", int'(bus.B_out), 0);
      exp_q.delete();
      dc = done_count;
      idle(2);
      rst_n = 1'b1;
      idle(10);
      chk("abort_no_done", done_count - dc, 0);
      issue(4'b1100, 4'b0101, 1'b0, 4'd7, 1'b0);
      finish_op(1'b0, n, bn);
      chk("post_reset_latency", n, WIDTH + 1);
      idle(2);

      chk("busy_done_overlap", overlap_count, 0);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
